// File: rtl/line_window_gen.sv
// line_window_gen: builds KxK sliding windows from a raster pixel stream.
// Pixels enter in raster order through a valid/ready handshake. K-1 line
// buffers give each column a K-deep vertical history, and a small column
// history register supplies the previous K-1 columns. A completed window is
// registered on the edge that accepts its bottom-right pixel and is held
// until the consumer takes it.
//
// Ports:
//   clock, rst_n          clock, asynchronous active-low reset
//   start                 one-cycle pulse: latch cfg_* and begin a tile
//   cfg_cols/rows/stride  tile geometry (stride 1 or 2)
//   in_valid/in_ready     pixel input handshake, pixel_in raster order
//   win_valid/win_ready   window output handshake
//   window_out            slot r*K+c at [(r*K+c)*WIDTH +: WIDTH], r=0 top row
//   done                  one-cycle pulse at tile end
//   cfg_err               one-cycle pulse when a start is rejected
module line_window_gen #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned MAX_COLS    = 32,
    parameter int unsigned COL_W       = 6
) (
    input  logic                                      clock,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [COL_W-1:0]                          cfg_cols,
    input  logic [COL_W-1:0]                          cfg_rows,
    input  logic [1:0]                                cfg_stride,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [WIDTH-1:0]                          pixel_in,
    output logic                                      win_valid,
    input  logic                                      win_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*WIDTH-1:0]  window_out,
    output logic                                      done,
    output logic                                      cfg_err
);

    localparam int unsigned K     = KERNEL_SIZE;
    localparam int unsigned WIN_W = K * K * WIDTH;
    localparam int unsigned AW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [COL_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   cols_q, cols_d;
    logic [COL_W-1:0]   rows_q, rows_d;
    logic [1:0]         stride_q, stride_d;
    logic               win_valid_q, win_valid_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    // Line buffers: line_mem[0] is one row up, line_mem[K-2] is K-1 rows up.
    logic [WIDTH-1:0]   line_mem [K-1][MAX_COLS];
    // Previous K-1 columns of the window; index K-2 is the most recent.
    logic [WIDTH-1:0]   hist_q [K][K-1];
    logic [WIDTH-1:0]   hist_d [K][K-1];

    logic [WIDTH-1:0]   newcol_c [K];
    logic [WIN_W-1:0]   win_next_c;
    logic [AW-1:0]      col_idx_c;
    logic               accept_c;
    logic               cfg_ok_c;
    logic               last_col_c;
    logic               last_row_c;
    logic               emit_c;
    logic               row_phase_c;
    logic               col_phase_c;

    assign in_ready   = (state_q == RUN) && (!win_valid_q || win_ready);
    assign win_valid  = win_valid_q;
    assign window_out = window_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

    assign accept_c  = in_valid && in_ready;
    assign col_idx_c = AW'(col_q);

    // Legal geometry: at least one full window fits and the row fits a buffer.
    assign cfg_ok_c = (cfg_cols >= COL_W'(K)) && (cfg_cols <= COL_W'(MAX_COLS)) &&
                      (cfg_rows >= COL_W'(K)) &&
                      ((cfg_stride == 2'd1) || (cfg_stride == 2'd2));

    assign last_col_c = (col_q == (cols_q - COL_W'(1)));
    assign last_row_c = (row_q == (rows_q - COL_W'(1)));

    // With stride 2, (x-K+1) is even exactly when x has the parity of K-1.
    assign row_phase_c = (row_q[0] == 1'(K - 1));
    assign col_phase_c = (col_q[0] == 1'(K - 1));
    assign emit_c = (row_q >= COL_W'(K - 1)) && (col_q >= COL_W'(K - 1)) &&
                    ((stride_q == 2'd1) || (row_phase_c && col_phase_c));

    // Vertical column ending at the incoming pixel, top row first.
    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            newcol_c[r] = pixel_in;
        end
        for (int unsigned r = 0; r < K - 1; r++) begin
            newcol_c[r] = line_mem[K - 2 - r][col_idx_c];
        end
    end

    // Candidate window: K-1 history columns followed by the new column.
    always_comb begin
        win_next_c = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                if (c < K - 1) begin
                    win_next_c[(r*K + c)*WIDTH +: WIDTH] = hist_q[r][c];
                end else begin
                    win_next_c[(r*K + c)*WIDTH +: WIDTH] = newcol_c[r];
                end
            end
        end
    end

    // Column history shift on each accepted pixel.
    always_comb begin
        hist_d = hist_q;
        if (accept_c) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c + 2 < K; c++) begin
                    hist_d[r][c] = hist_q[r][c + 1];
                end
                hist_d[r][K - 2] = newcol_c[r];
            end
        end
    end

    // FSM, counters, configuration latch and output registers.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        stride_d    = stride_q;
        win_valid_d = win_valid_q;
        window_d    = window_q;
        cfg_err_d   = 1'b0;
        done_d      = 1'b0;

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok_c) begin
                        state_d  = RUN;
                        cols_d   = cfg_cols;
                        rows_d   = cfg_rows;
                        stride_d = cfg_stride;
                        col_d    = '0;
                        row_d    = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept_c) begin
                    // A new window on a handshake edge replaces the old one.
                    if (emit_c) begin
                        win_valid_d = 1'b1;
                        window_d    = win_next_c;
                    end
                    if (last_col_c) begin
                        col_d = '0;
                        if (last_row_c) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + COL_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!win_valid_q || win_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            stride_q    <= '0;
            win_valid_q <= 1'b0;
            window_q    <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            stride_q    <= stride_d;
            win_valid_q <= win_valid_d;
            window_q    <= window_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Pixel storage carries no reset; stale contents are never windowed.
    always_ff @(posedge clock) begin
        hist_q <= hist_d;
        if (accept_c) begin
            line_mem[0][col_idx_c] <= pixel_in;
            for (int unsigned j = 1; j < K - 1; j++) begin
                line_mem[j][col_idx_c] <= line_mem[j - 1][col_idx_c];
            end
        end
    end

endmodule
